// File: rtl/morse_encoder.sv
// ASCII-to-Morse transmitter: timed key output plus a 2-bit symbol stream
// (01 dot, 10 dash, 11 end-of-letter/word) matching the Morse decoder input code.
module morse_encoder #(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic [1:0] symbol,
  output logic       symbol_valid,
  output logic       busy,
  output logic       bad_char
);

  typedef enum logic [2:0] {IDLE, ELEM_ON, ELEM_GAP, LETTER_GAP, WORD_GAP, BAD} state_t;

  localparam logic [CNT_W-1:0] DOT_T  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_T = CNT_W'(3*UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WGAP_T = CNT_W'(7*UNIT_CYCLES - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       pat, pat_d;     // remaining elements, MSB next, 1 = dash
  logic [2:0]       rem, rem_d;     // elements left including the current one
  logic             first, first_d; // first cycle of the current state
  logic             live;           // low until the cycle after reset releases

  // {length, left-aligned pattern}
  function automatic logic [6:0] lookup(input logic [4:0] idx);
    case (idx)
      5'd0:  lookup = {3'd2, 4'b0100}; 5'd1:  lookup = {3'd4, 4'b1000};
      5'd2:  lookup = {3'd4, 4'b1010}; 5'd3:  lookup = {3'd3, 4'b1000};
      5'd4:  lookup = {3'd1, 4'b0000}; 5'd5:  lookup = {3'd4, 4'b0010};
      5'd6:  lookup = {3'd3, 4'b1100}; 5'd7:  lookup = {3'd4, 4'b0000};
      5'd8:  lookup = {3'd2, 4'b0000}; 5'd9:  lookup = {3'd4, 4'b0111};
      5'd10: lookup = {3'd3, 4'b1010}; 5'd11: lookup = {3'd4, 4'b0100};
      5'd12: lookup = {3'd2, 4'b1100}; 5'd13: lookup = {3'd2, 4'b1000};
      5'd14: lookup = {3'd3, 4'b1110}; 5'd15: lookup = {3'd4, 4'b0110};
      5'd16: lookup = {3'd4, 4'b1101}; 5'd17: lookup = {3'd3, 4'b0100};
      5'd18: lookup = {3'd3, 4'b0000}; 5'd19: lookup = {3'd1, 4'b1000};
      5'd20: lookup = {3'd3, 4'b0010}; 5'd21: lookup = {3'd4, 4'b0001};
      5'd22: lookup = {3'd3, 4'b0110}; 5'd23: lookup = {3'd4, 4'b1001};
      5'd24: lookup = {3'd4, 4'b1011}; 5'd25: lookup = {3'd4, 4'b1100};
      default: lookup = {3'd1, 4'b0000};
    endcase
  endfunction

  logic       is_upper, is_lower;
  logic [4:0] idx;
  assign is_upper = (char_in >= 8'd65) && (char_in <= 8'd90);
  assign is_lower = (char_in >= 8'd97) && (char_in <= 8'd122);
  assign idx      = is_upper ? 5'(char_in - 8'd65) : 5'(char_in - 8'd97);

  always_comb begin
    state_d = state;
    cnt_d   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
    pat_d   = pat;
    rem_d   = rem;
    first_d = 1'b0;
    case (state)
      IDLE: if (char_valid && char_ready) begin
        first_d = 1'b1;
        if (is_upper || is_lower) begin
          {rem_d, pat_d} = lookup(idx);
          state_d        = ELEM_ON;
          cnt_d          = pat_d[3] ? DASH_T : DOT_T;
        end else if (char_in == 8'd32) begin
          state_d = WORD_GAP;
          cnt_d   = WGAP_T;
        end else begin
          state_d = BAD;
        end
      end
      ELEM_ON: if (cnt == '0) begin
        first_d = 1'b1;
        rem_d   = rem - 3'd1;
        pat_d   = {pat[2:0], 1'b0};
        if (rem == 3'd1) begin
          state_d = LETTER_GAP;
          cnt_d   = DASH_T;
        end else begin
          state_d = ELEM_GAP;
          cnt_d   = DOT_T;
        end
      end
      ELEM_GAP: if (cnt == '0) begin
        first_d = 1'b1;
        state_d = ELEM_ON;
        cnt_d   = pat[3] ? DASH_T : DOT_T;
      end
      LETTER_GAP, WORD_GAP: if (cnt == '0) state_d = IDLE;
      BAD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pat   <= '0;
      rem   <= '0;
      first <= 1'b0;
      live  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pat   <= pat_d;
      rem   <= rem_d;
      first <= first_d;
      live  <= 1'b1;
    end
  end

  always_comb begin
    char_ready   = (state == IDLE) && live;
    busy         = (state != IDLE);
    key_out      = (state == ELEM_ON);
    bad_char     = (state == BAD);
    symbol_valid = first && (state == ELEM_ON || state == LETTER_GAP || state == WORD_GAP);
    symbol       = 2'b00;
    if (symbol_valid)
      symbol = (state != ELEM_ON) ? 2'b11 : (pat[3] ? 2'b10 : 2'b01);
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboarded bench for morse_encoder: three instances (U=4,2,1), expected
// strobes queued at issue time and matched by an independent monitor.
module tb_morse_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic cv[3];
  logic rdy[3], key[3], sv[3], busy[3], bad[3];
  logic [1:0] sym[3];

  always #5 clk = ~clk;

  morse_encoder #(.UNIT_CYCLES(4), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(cv[0]), .char_ready(rdy[0]),
    .key_out(key[0]), .symbol(sym[0]), .symbol_valid(sv[0]), .busy(busy[0]), .bad_char(bad[0]));
  morse_encoder #(.UNIT_CYCLES(2), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(cv[1]), .char_ready(rdy[1]),
    .key_out(key[1]), .symbol(sym[1]), .symbol_valid(sv[1]), .busy(busy[1]), .bad_char(bad[1]));
  morse_encoder #(.UNIT_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(cv[2]), .char_ready(rdy[2]),
    .key_out(key[2]), .symbol(sym[2]), .symbol_valid(sv[2]), .busy(busy[2]), .bad_char(bad[2]));

  typedef struct {
    int         cyc;
    logic [1:0] sym;
    logic       bad;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0;
  int   cyc = 0, t0 = 0, sel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe on the selected instance must match the queue head.
  always @(negedge clk) begin
    if (sv[sel] === 1'b1 || bad[sel] === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", {sym[sel], bad[sel]}, 64'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe", {32'(cyc - t0), 29'd0, sym[sel], bad[sel]}, {32'(e.cyc - t0), 29'd0, e.sym, e.bad});
      end
    end
  end

  task automatic push(input int off, input logic [1:0] s, input logic b);
    exp_t e;
    e.cyc = t0 + off; e.sym = s; e.bad = b;
    q.push_back(e);
  endtask

  // Waits for ready at a negedge, presents the character for that cycle (cycle 0).
  task automatic xfer(input int s, input logic [7:0] c);
    int n = 0;
    while (rdy[s] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      chk("ready_timeout", 64'd0, 64'd1);
      $display("FAIL ready_timeout: design never became ready");
      $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails);
    end
    char_in = c;
    cv[s]   = 1'b1;
    t0      = cyc;
  endtask

  // Collects key_out for cycles 1..rdy_at and checks the first ready cycle.
  task automatic run(input string name, input int s, input logic [63:0] kmask, input int rdy_at);
    logic [63:0] km = '0;
    int first_rdy = -1;
    logic bz_ok = 1'b1;
    for (int k = 1; k <= rdy_at; k++) begin
      @(negedge clk);
      cv[s] = 1'b0;
      char_in = 8'hxx;
      km[k] = key[s];
      if (busy[s] !== ~rdy[s]) bz_ok = 1'b0;
      if (rdy[s] === 1'b1 && first_rdy < 0) first_rdy = k;
    end
    chk({name, "_key"}, km, kmask);
    chk({name, "_ready_cycle"}, 64'(first_rdy), 64'(rdy_at));
    chk({name, "_busy"}, 64'(bz_ok), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cv[i] = 1'b0;

    // Reset with valid asserted: nothing may transfer or strobe.
    sel = 0; cv[0] = 1'b1; char_in = "E";
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {rdy[0], key[0], sv[0], sym[0], busy[0], bad[0]}, 64'h0);
    end
    cv[0] = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {rdy[0], busy[0]}, 64'b10);

    // 'E', U=4
    xfer(0, "E"); push(1, 2'b01, 0); push(5, 2'b11, 0);
    run("E_u4", 0, 64'h1E, 17);

    // 'q', U=2 -> Q
    sel = 1;
    xfer(1, "q"); push(1, 2'b10, 0); push(9, 2'b10, 0); push(17, 2'b01, 0);
    push(21, 2'b10, 0); push(27, 2'b11, 0);
    run("q_u2", 1, 64'h07E6_7E7E, 33);

    // Space then bad character, U=2
    xfer(1, " "); push(1, 2'b11, 0);
    run("space_u2", 1, 64'h0, 15);
    xfer(1, "1"); push(1, 2'b00, 1);
    run("bad_u2", 1, 64'h0, 2);

    // Back-to-back "ET", valid held, U=1
    sel = 2;
    begin
      logic [63:0] km = '0;
      int t_second = -1;
      xfer(2, "E");
      push(1, 2'b01, 0); push(2, 2'b11, 0); push(6, 2'b10, 0); push(9, 2'b11, 0);
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 1) char_in = "T";
        if (t_second > 0 && k > t_second) cv[2] = 1'b0;
        km[k] = key[2];
        if (rdy[2] === 1'b1 && t_second < 0) t_second = k;
      end
      chk("ET_second_xfer", 64'(t_second), 64'd5);
      chk("ET_key", km, 64'h1C2);
      chk("ET_ready_again", 64'(rdy[2]), 64'd1);
    end

    // Reset in the middle of a dash, U=4
    sel = 0;
    xfer(0, "T"); push(1, 2'b10, 0);
    @(negedge clk); cv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("T_key_before_reset", 64'(key[0]), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("T_key_after_reset", {key[0], busy[0], rdy[0]}, 64'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("queue_after_abort", 64'(q.size()), 64'd0);
    xfer(0, "E"); push(1, 2'b01, 0); push(5, 2'b11, 0);
    run("E_after_reset", 0, 64'h1E, 17);

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
Converts ASCII characters into timed Morse keying and a per-element symbol stream. This is the transmit side of the Morse path. The symbol stream uses the same 2-bit code that the Morse decoder FSM consumes: 01 dot, 10 dash, 11 send/end-of-letter, 00 idle. The encoder sits between a character source (UART/keyboard buffer) and the key/tone driver, and can loop back into the decoder for self-test.

Parameters:
UNIT_CYCLES, 4, clock cycles per Morse time unit (must be >= 1)
CNT_W, 16, width of the unit/element timing counter (must hold 7*UNIT_CYCLES)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
char_in  input  8  ASCII character to send
char_valid  input  1  char_in valid
char_ready  output  1  encoder can accept a character this cycle
key_out  output  1  Morse key, 1 = tone on
symbol  output  2  01 dot, 10 dash, 11 end-of-letter/word, 00 when symbol_valid=0
symbol_valid  output  1  one-cycle strobe qualifying symbol
busy  output  1  1 whenever state != IDLE
bad_char  output  1  one-cycle strobe when an unsupported character was accepted

Behaviour:
- Interface: one clock domain, clk. Reset is rst_n, synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state=IDLE. char_ready=0, key_out=0, symbol=00, symbol_valid=0, busy=0, bad_char=0. char_ready=1 from the first cycle after rst_n rises.
- Reset mid-operation aborts at once. key_out drops on that edge and the partial letter is discarded (no 11 strobe).
- Handshake: transfer occurs when char_valid && char_ready. char_ready=1 only in IDLE. char_in is sampled only on the transfer cycle (call it cycle 0).
- Character map:
  - 'A'-'Z' (65-90) map to standard ITU patterns of 1-4 elements, sent MSB-first.
  - 'a'-'z' (97-122) map identically to uppercase.
  - ' ' (32) is a word space.
  - All other values are bad.
- States: IDLE, ELEM_ON, ELEM_GAP, LETTER_GAP, WORD_GAP, BAD.
- Letter timing (U = UNIT_CYCLES), relative to cycle 0:
  - ELEM_ON: key_out=1 for U cycles (dot) or 3U cycles (dash). symbol_valid=1 with symbol 01 or 10 in the first ELEM_ON cycle only. First element starts at cycle 1.
  - ELEM_GAP: key_out=0 for U cycles between elements of the same letter.
  - LETTER_GAP: follows the last element instead of ELEM_GAP. key_out=0 for 3U cycles. symbol_valid=1, symbol=11 in its first cycle.
  - After LETTER_GAP the state returns to IDLE (char_ready=1).
  - Example: 'E' with U=4 gives key_out=1 in cycles 1-4 and 0 in cycles 5-16; ready in cycle 17.
- Space: WORD_GAP holds key_out=0 for 7U cycles (cycles 1..7U). symbol_valid=1, symbol=11 in cycle 1. IDLE in cycle 7U+1.
- Bad character: BAD for cycle 1 only. bad_char=1, no symbols, key_out=0. IDLE (ready) in cycle 2.
- Back-to-back: with char_valid held high, the next transfer occurs in the first IDLE cycle. There are no extra idle cycles, and gaps are never shortened.
- Counter: loads its terminal count on each state entry and decrements to 0. There is no wrap-around, and no overflow for legal CNT_W.
- char_valid while not ready is ignored, and char_in may change freely then.
- busy=0 exactly when char_ready=1 (outside reset).

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with char_valid=1 -> all outputs 0, no transfer. char_ready=1 the cycle after rst_n rises.
2. 'E' (0x45), U=4 -> symbol 01 strobe at cycle 1; key_out=1 in cycles 1-4; symbol 11 strobe at cycle 5; char_ready=1 at cycle 17.
3. 'q' (0x71), U=2 -> sent as Q (dash dash dot dash):
   - key_out high in cycles 1-6, 9-14, 17-18, 21-26.
   - Strobes 10,10,01,10 at cycles 1, 9, 17, 21; strobe 11 at cycle 27.
   - char_ready at cycle 33.
4. ' ' (0x20), U=2 -> strobe 11 at cycle 1; key_out=0 in cycles 1-14; ready at cycle 15. Then '1' (0x31) -> bad_char=1 one cycle, no symbols, ready 2 cycles after transfer.
5. Back-to-back "ET" with char_valid held, U=1 -> E keyed in cycle 1, ready at cycle 5 and T accepted there. T keyed cycles 6-8, strobe 11 at cycle 9.
6. Reset mid-dash: 'T', U=4, rst_n=0 at cycle 5 -> key_out=0 from that edge, no 11 strobe. The next 'E' encodes normally.
